vxe_biu_client_arb: RTL
=======================

Name: vxe_biu_client_arb

Overview:
- Shares one AXI4 master BIU (single-beat, pop/push FIFO-style interface) between NCL=4 clients.
- Request paths (AW+W combined, AR) use round-robin arbitration. The grant index is stamped into the BIU client-ID.
- Response paths (B, R) are buffered in 2-entry FIFOs and demultiplexed to clients by the returned client-ID.
- Sits between the per-client request/response queues and the BIU.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
CID_WIDTH, 8, BIU client-ID width (>=2); NCL fixed at 4, client index = CID[1:0]

Ports:
M_AXI4_ACLK  in  1  clock
M_AXI4_ARESETn  in  1  async active-low reset
cl_awaddr  in  4*ADDR_WIDTH  per-client write address; client i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
cl_awdata  in  4*DATA_WIDTH  per-client write data
cl_awstrb  in  4*DATA_WIDTH/8  per-client byte strobes
cl_awvalid  in  4  client write queue non-empty
cl_awpop  out  4  dequeue client write head
cl_araddr  in  4*ADDR_WIDTH  per-client read address
cl_arvalid  in  4  client read queue non-empty
cl_arpop  out  4  dequeue client read head
cl_bresp  out  2  broadcast write response
cl_bready  in  4  client B queue can accept
cl_bpush  out  4  write response push strobe, one-hot
cl_rdata  out  DATA_WIDTH  broadcast read data
cl_rresp  out  2  broadcast read response
cl_rready  in  4  client R queue can accept
cl_rpush  out  4  read response push strobe, one-hot
biu_awcid/awaddr/awdata/awstrb  out  CID_WIDTH/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  muxed write request
biu_awvalid  out  1  muxed write valid
biu_awpop  in  1  BIU write dequeue
biu_bcid  in  CID_WIDTH  write response ID
biu_bresp  in  2  write response
biu_bready  out  1  write response FIFO not full
biu_bpush  in  1  write response valid
biu_arcid/araddr  out  CID_WIDTH/ADDR_WIDTH  muxed read request
biu_arvalid  out  1  muxed read valid
biu_arpop  in  1  BIU read dequeue
biu_rcid  in  CID_WIDTH  read response ID
biu_rdata  in  DATA_WIDTH  read response data
biu_rresp  in  2  read response
biu_rready  out  1  read response FIFO not full
biu_rpush  in  1  read response valid

Behaviour:
- Reset: M_AXI4_ARESETn, asynchronous, active-low; clock M_AXI4_ACLK.
  - On reset: grant registers awg=arg=0, FIFOs empty, all cl_*push=0, cl_bresp/cl_rresp/cl_rdata=0.
- Request mux (AW and AR paths identical and independent; AW described):
  - Combinational: biu_awvalid=cl_awvalid[awg]; biu_aw* = client awg fields; biu_awcid = awg zero-extended to CID_WIDTH.
  - cl_awpop[i] = biu_awpop & (awg==i) & cl_awvalid[i]. A pop while the muxed valid is low is ignored.
  - A transfer happens on an edge with biu_awpop & biu_awvalid.
- Grant update at each edge, when a transfer happens or cl_awvalid[awg]=0:
  - awg <= first requesting client in order awg+1, awg+2, awg+3 (mod 4).
  - If no other client is requesting, awg holds.
  - Grant therefore moves after every consumed request, giving strict per-transaction round-robin.
- Response FIFO (B; R identical with data): 2 entries of {cid,resp[,data]}.
  - biu_bready = !full (combinational).
  - Entry accepted on an edge with biu_bpush & biu_bready.
  - Simultaneous accept and drain allowed; a full FIFO that drains this cycle still reports full (no bypass).
- Response demux, registered, each edge:
  - Head not empty, head cid[CID_WIDTH-1:2]==0, and cl_bready[cid[1:0]]=1: cl_bpush <= onehot(cid[1:0]), cl_bresp <= head resp, pop head.
  - Head not empty but cid upper bits nonzero: pop and discard, cl_bpush <= 0.
  - Otherwise cl_bpush <= 0 and head holds; head-of-line blocking is accepted.
  - cl_bpush is a single-cycle strobe; data holds until the next push.
- Latency:
  - Request: zero cycles, combinational mux.
  - Response: BIU accept at edge N, cl_*push high in the cycle after edge N+1.
- Reset mid-operation: pending FIFO entries are lost and grants return to 0. BIU and clients are reset together.

Test Plan:
- Single client 2 writes: cl_awvalid=0010, BIU pops twice → cl_awpop[1] pulses twice, biu_awcid=1 both; awg stays 1.
- All 4 clients continuously valid on AR, 8 pops → biu_arcid sequence 0,1,2,3,0,1,2,3 (grant from reset 0).
- Client 2 drops valid while granted, client 3 valid → awg→3 next edge; biu_awpop in that cycle with valid 0 pops no client.
- B responses cid 3 then cid 0, cl_bready=1111 → cl_bpush 1000 then 0001 on consecutive cycles, cl_bresp matches each.
- cl_rready[1]=0, three R pushes cid 1 → two accepted, biu_rready=0 on third; release ready → cl_rpush[1] twice, then third accepted.
- R response with cid=8'h05 → discarded, no cl_rpush. A following cid=8'h02 push is delivered to client 2.

Source files
------------

// File: rtl/vxe_biu_client_arb.sv
// rtl/vxe_biu_client_arb.sv - four-client round-robin arbiter and response demux in front of a single-beat AXI4 BIU

module vxe_biu_client_arb_rsp #(
    parameter int W = 8
) (
    input  logic         M_AXI4_ACLK,
    input  logic         M_AXI4_ARESETn,
    input  logic [W-1:0] push_data,
    input  logic         push,
    output logic         ready,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         not_empty
);
    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic [1:0]   count;
    logic         acc;

    // ready is purely !full: a full FIFO draining this cycle still refuses new data
    assign ready     = (count != 2'd2);
    assign not_empty = (count != 2'd0);
    assign head      = mem[rptr];
    assign acc       = push & ready;

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (acc) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            if (acc && !pop)      count <= count + 2'd1;
            else if (!acc && pop) count <= count - 2'd1;
        end
    end
endmodule

module vxe_biu_client_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CID_WIDTH  = 8
) (
    input  logic                      M_AXI4_ACLK,
    input  logic                      M_AXI4_ARESETn,
    input  logic [4*ADDR_WIDTH-1:0]   cl_awaddr,
    input  logic [4*DATA_WIDTH-1:0]   cl_awdata,
    input  logic [4*DATA_WIDTH/8-1:0] cl_awstrb,
    input  logic [3:0]                cl_awvalid,
    output logic [3:0]                cl_awpop,
    input  logic [4*ADDR_WIDTH-1:0]   cl_araddr,
    input  logic [3:0]                cl_arvalid,
    output logic [3:0]                cl_arpop,
    output logic [1:0]                cl_bresp,
    input  logic [3:0]                cl_bready,
    output logic [3:0]                cl_bpush,
    output logic [DATA_WIDTH-1:0]     cl_rdata,
    output logic [1:0]                cl_rresp,
    input  logic [3:0]                cl_rready,
    output logic [3:0]                cl_rpush,
    output logic [CID_WIDTH-1:0]      biu_awcid,
    output logic [ADDR_WIDTH-1:0]     biu_awaddr,
    output logic [DATA_WIDTH-1:0]     biu_awdata,
    output logic [DATA_WIDTH/8-1:0]   biu_awstrb,
    output logic                      biu_awvalid,
    input  logic                      biu_awpop,
    input  logic [CID_WIDTH-1:0]      biu_bcid,
    input  logic [1:0]                biu_bresp,
    output logic                      biu_bready,
    input  logic                      biu_bpush,
    output logic [CID_WIDTH-1:0]      biu_arcid,
    output logic [ADDR_WIDTH-1:0]     biu_araddr,
    output logic                      biu_arvalid,
    input  logic                      biu_arpop,
    input  logic [CID_WIDTH-1:0]      biu_rcid,
    input  logic [DATA_WIDTH-1:0]     biu_rdata,
    input  logic [1:0]                biu_rresp,
    output logic                      biu_rready,
    input  logic                      biu_rpush
);
    localparam int BW = CID_WIDTH + 2;
    localparam int RW = CID_WIDTH + 2 + DATA_WIDTH;

    logic [1:0] awg;
    logic [1:0] arg;

    // First requester after g in circular order; holds g when nobody else asks
    function automatic logic [1:0] rr_next(input logic [1:0] g, input logic [3:0] v);
        logic [1:0] c;
        rr_next = g;
        for (int k = 3; k >= 1; k--) begin
            c = g + 2'(k);
            if (v[c]) rr_next = c;
        end
    endfunction

    assign biu_awvalid = cl_awvalid[awg];
    assign biu_awaddr  = cl_awaddr[awg*ADDR_WIDTH +: ADDR_WIDTH];
    assign biu_awdata  = cl_awdata[awg*DATA_WIDTH +: DATA_WIDTH];
    assign biu_awstrb  = cl_awstrb[awg*(DATA_WIDTH/8) +: DATA_WIDTH/8];
    assign biu_awcid   = {{(CID_WIDTH-2){1'b0}}, awg};
    assign cl_awpop    = {4{biu_awpop}} & cl_awvalid & (4'b0001 << awg);

    assign biu_arvalid = cl_arvalid[arg];
    assign biu_araddr  = cl_araddr[arg*ADDR_WIDTH +: ADDR_WIDTH];
    assign biu_arcid   = {{(CID_WIDTH-2){1'b0}}, arg};
    assign cl_arpop    = {4{biu_arpop}} & cl_arvalid & (4'b0001 << arg);

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            awg <= 2'd0;
            arg <= 2'd0;
        end else begin
            if ((biu_awpop && biu_awvalid) || !cl_awvalid[awg]) awg <= rr_next(awg, cl_awvalid);
            if ((biu_arpop && biu_arvalid) || !cl_arvalid[arg]) arg <= rr_next(arg, cl_arvalid);
        end
    end

    logic [BW-1:0]        b_head;
    logic                 b_ne;
    logic                 b_pop;
    logic [RW-1:0]        r_head;
    logic                 r_ne;
    logic                 r_pop;
    logic [CID_WIDTH-1:0] b_cid;
    logic [CID_WIDTH-1:0] r_cid;
    logic                 b_foreign;
    logic                 r_foreign;

    vxe_biu_client_arb_rsp #(.W(BW)) u_bfifo (
        .M_AXI4_ACLK    (M_AXI4_ACLK),
        .M_AXI4_ARESETn (M_AXI4_ARESETn),
        .push_data      ({biu_bcid, biu_bresp}),
        .push           (biu_bpush),
        .ready          (biu_bready),
        .pop            (b_pop),
        .head           (b_head),
        .not_empty      (b_ne)
    );

    vxe_biu_client_arb_rsp #(.W(RW)) u_rfifo (
        .M_AXI4_ACLK    (M_AXI4_ACLK),
        .M_AXI4_ARESETn (M_AXI4_ARESETn),
        .push_data      ({biu_rcid, biu_rresp, biu_rdata}),
        .push           (biu_rpush),
        .ready          (biu_rready),
        .pop            (r_pop),
        .head           (r_head),
        .not_empty      (r_ne)
    );

    // IDs outside the four-client range are dropped rather than stalling the queue
    always_comb begin
        b_cid     = b_head[BW-1:2];
        r_cid     = r_head[RW-1:2+DATA_WIDTH];
        b_foreign = (b_cid >> 2) != '0;
        r_foreign = (r_cid >> 2) != '0;
        b_pop     = b_ne & (b_foreign | cl_bready[b_cid[1:0]]);
        r_pop     = r_ne & (r_foreign | cl_rready[r_cid[1:0]]);
    end

    always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
        if (!M_AXI4_ARESETn) begin
            cl_bpush <= 4'b0;
            cl_bresp <= 2'b0;
            cl_rpush <= 4'b0;
            cl_rresp <= 2'b0;
            cl_rdata <= '0;
        end else begin
            cl_bpush <= 4'b0;
            cl_rpush <= 4'b0;
            if (b_pop && !b_foreign) begin
                cl_bpush <= 4'b0001 << b_cid[1:0];
                cl_bresp <= b_head[1:0];
            end
            if (r_pop && !r_foreign) begin
                cl_rpush <= 4'b0001 << r_cid[1:0];
                cl_rresp <= r_head[DATA_WIDTH+1:DATA_WIDTH];
                cl_rdata <= r_head[DATA_WIDTH-1:0];
            end
        end
    end
endmodule
